// File: rtl/rob_ctrl_pkg.sv
// Shared reorder-buffer sizing constants and tag type for issue, RS and ROB data array.
package rob_ctrl_pkg;
  localparam int unsigned ROB_DEPTH = 32;
  localparam int unsigned ROB_TAG_W = $clog2(ROB_DEPTH);
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
endpackage

// File: rtl/rob_ptr_counter.sv
// Wrapping ROB pointer with increment and synchronous clear; used for head and tail.
module rob_ptr_counter #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
  end
endmodule

// File: rtl/rob_ctrl.sv
// ROB allocation / in-order retirement controller with mispredict flush.
// Optional ROB_CDB_BYPASS_EN: CDB writeback to the head entry may retire in the same cycle.
module rob_ctrl
  import rob_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = ROB_DEPTH,
  parameter int unsigned TAG_W = ROB_TAG_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             alloc_req_in,
  output logic             alloc_ack_out,
  output logic [TAG_W-1:0] alloc_tag_out,
  input  logic             cdb_valid_in,
  input  logic [TAG_W-1:0] cdb_tag_in,
  input  logic             cdb_mispredict_in,
  output logic             commit_valid_out,
  output logic [TAG_W-1:0] commit_tag_out,
  input  logic             commit_ready_in,
  output logic             flush_out,
  output logic             full_out,
  output logic             empty_out,
  output logic [TAG_W:0]   count_out
);
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;
  logic [DEPTH-1:0] valid, ready, mispred;
  logic             full, empty, commit_ok, head_mispred;
  logic             retire, flush_commit, ack, wb;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  always_comb begin
    commit_ok    = valid[head] & ready[head];
    head_mispred = mispred[head];
`ifdef ROB_CDB_BYPASS_EN
    // A writeback landing on the head this cycle stands in for the ready/mispred bits.
    if (valid[head] && cdb_valid_in && (cdb_tag_in == head)) begin
      commit_ok    = 1'b1;
      head_mispred = cdb_mispredict_in;
    end
`endif
  end

  assign retire       = rdy_in & commit_ok & commit_ready_in;
  assign flush_commit = retire & head_mispred;
  assign ack          = rdy_in & alloc_req_in & ~full & ~flush_commit;
  assign wb           = rdy_in & cdb_valid_in & valid[cdb_tag_in] & ~flush_commit;

  rob_ptr_counter #(.W(TAG_W)) u_head (
    .clk(clk_in), .rst_n(rst_in), .inc(retire), .clr(flush_commit), .ptr(head)
  );

  rob_ptr_counter #(.W(TAG_W)) u_tail (
    .clk(clk_in), .rst_n(rst_in), .inc(ack), .clr(flush_commit), .ptr(tail)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid   <= '0;
      ready   <= '0;
      mispred <= '0;
    end else if (flush_commit) begin
      valid   <= '0;
      ready   <= '0;
      mispred <= '0;
    end else begin
      if (wb) begin
        ready[cdb_tag_in]   <= 1'b1;
        mispred[cdb_tag_in] <= cdb_mispredict_in;
      end
      if (retire) valid[head] <= 1'b0;
      if (ack) begin
        valid[tail]   <= 1'b1;
        ready[tail]   <= 1'b0;
        mispred[tail] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      count     <= '0;
      flush_out <= 1'b0;
    end else if (rdy_in) begin
      flush_out <= flush_commit;
      if (flush_commit) count <= '0;
      else begin
        case ({ack, retire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  assign alloc_ack_out    = ack;
  assign alloc_tag_out    = tail;
  assign commit_valid_out = commit_ok;
  assign commit_tag_out   = head;
  assign full_out         = full;
  assign empty_out        = empty;
  assign count_out        = count;
endmodule

// File: tb/tb_rob_ctrl.sv
// Self-checking bench for rob_ctrl: queue-based reference model plus directed literal checks.
module tb_rob_ctrl;
  localparam int D = 32;

  logic       clk = 1'b0;
  logic       rst_n, rdy, req, ack, cv, cready, cdbv, cdbm, flush, full, empty;
  logic [4:0] atag, ctag, cdbt;
  logic [5:0] count;

  int total = 0;
  int bad   = 0;

  rob_ctrl #(.DEPTH(32), .TAG_W(5)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
    .alloc_req_in(req), .alloc_ack_out(ack), .alloc_tag_out(atag),
    .cdb_valid_in(cdbv), .cdb_tag_in(cdbt), .cdb_mispredict_in(cdbm),
    .commit_valid_out(cv), .commit_tag_out(ctag), .commit_ready_in(cready),
    .flush_out(flush), .full_out(full), .empty_out(empty), .count_out(count)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: in-flight entries kept oldest-first in a queue.
  typedef struct {int tag; bit rdy; bit mp;} ent_t;
  ent_t q[$];
  int   m_head = 0, m_tail = 0;
  bit   m_flush = 1'b0;
  int   n;
  bit   e_cv, e_mp, e_ret, e_fl, e_ack;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_head = 0; m_tail = 0; m_flush = 1'b0;
    end else begin
      n    = q.size();
      e_cv = (n > 0) && q[0].rdy;
      e_mp = (n > 0) && q[0].mp;
`ifdef ROB_CDB_BYPASS_EN
      if (n > 0 && cdbv && int'(cdbt) == q[0].tag) begin
        e_cv = 1'b1;
        e_mp = cdbm;
      end
`endif
      e_ret = rdy && e_cv && cready;
      e_fl  = e_ret && e_mp;
      e_ack = rdy && req && (n != D) && !e_fl;
      cmp("m_ack", ack, e_ack);
      cmp("m_alloc_tag", atag, m_tail);
      cmp("m_commit_valid", cv, e_cv);
      cmp("m_commit_tag", ctag, m_head);
      cmp("m_flush", flush, m_flush);
      cmp("m_full", full, n == D);
      cmp("m_empty", empty, n == 0);
      cmp("m_count", count, n);
      if (rdy) begin
        m_flush = e_fl;
        if (e_fl) begin
          q.delete();
          m_head = 0; m_tail = 0;
        end else begin
          if (cdbv) foreach (q[i]) if (q[i].tag == int'(cdbt)) begin
            q[i].rdy = 1'b1;
            q[i].mp  = cdbm;
          end
          if (e_ret) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % D;
          end
          if (e_ack) begin
            q.push_back('{tag: m_tail, rdy: 1'b0, mp: 1'b0});
            m_tail = (m_tail + 1) % D;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string nm);
    for (int k = 0; k < 80 && !empty; k++) tick();
    cmp(nm, empty, 1);
  endtask

  task automatic alloc_n(input int k);
    req = 1'b1;
    for (int i = 0; i < k; i++) tick();
    req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; req = 1'b0; cready = 1'b0;
    cdbv = 1'b0; cdbt = '0; cdbm = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    cmp("rst_empty", empty, 1);
    cmp("rst_count", count, 0);
    cmp("rst_commit_valid", cv, 0);
    cmp("rst_flush", flush, 0);
    cmp("rst_alloc_tag", atag, 0);
    tick();

    // Fill all 32 entries, then one more request.
    for (int i = 0; i < D; i++) begin
      req = 1'b1;
      #1;
      cmp("fill_ack", ack, 1);
      cmp("fill_tag", atag, i);
      tick();
    end
    cmp("fill_full", full, 1);
    cmp("fill_count", count, 32);
    #1;
    cmp("over_ack", ack, 0);
    tick();
    req = 1'b0;
    cready = 1'b1;
    for (int i = 0; i < D; i++) begin
      cdbv = 1'b1; cdbt = 5'(i);
      tick();
    end
    cdbv = 1'b0;
    wait_empty("fill_drain_empty");
    cready = 1'b0;

    // Out-of-order writeback, in-order commit.
    alloc_n(3);
    cdbv = 1'b1; cdbt = 5'd2; tick();
    cdbt = 5'd1; tick();
    cdbt = 5'd0; tick();
    cdbv = 1'b0; cready = 1'b1;
    #1;
    cmp("ooo_cv0", cv, 1);
    cmp("ooo_tag0", ctag, 0);
    tick();
    cmp("ooo_tag1", ctag, 1);
    tick();
    cmp("ooo_tag2", ctag, 2);
    tick();
    cmp("ooo_empty", empty, 1);
    cready = 1'b0;

    // Asynchronous reset with entries in flight.
    alloc_n(2);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_count", count, 0);
    cmp("arst_alloc_tag", atag, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // Mispredict on tag 1 flushes after it retires.
    alloc_n(4);
    cdbv = 1'b1; cdbt = 5'd0; tick();
    cdbt = 5'd1; cdbm = 1'b1; tick();
    cdbv = 1'b0; cdbm = 1'b0; cready = 1'b1;
    #1;
    cmp("mp_tag0", ctag, 0);
    tick();
    cmp("mp_tag1", ctag, 1);
    req = 1'b1;
    #1;
    cmp("mp_alloc_refused", ack, 0);
    tick();
    req = 1'b0;
    cmp("mp_flush_hi", flush, 1);
    cmp("mp_count", count, 0);
    cmp("mp_alloc_tag", atag, 0);
    tick();
    cmp("mp_flush_lo", flush, 0);
    cready = 1'b0;

    // Stalled commit, fill to 32 while head held, full blocks ack despite retire.
    alloc_n(31);
    cdbv = 1'b1; cdbt = 5'd0; tick();
    cdbv = 1'b0;
    req = 1'b1;
    #1;
    cmp("stall_ack31", ack, 1);
    tick();
    req = 1'b0;
    cmp("stall_full", full, 1);
    cmp("stall_count", count, 32);
    cmp("stall_tag_a", ctag, 0);
    tick();
    cmp("stall_tag_b", ctag, 0);
    cmp("stall_cv", cv, 1);
    req = 1'b1; cready = 1'b1;
    #1;
    cmp("full_retire_ack", ack, 0);
    tick();
    req = 1'b0;
    cmp("full_retire_count", count, 31);
    for (int i = 1; i < D; i++) begin
      cdbv = 1'b1; cdbt = 5'(i);
      tick();
    end
    cdbv = 1'b0;
    wait_empty("stall_drain_empty");
    cready = 1'b0;

    // rdy low freezes everything.
    alloc_n(2);
    rdy = 1'b0; req = 1'b1; cdbv = 1'b1; cdbt = 5'd0; cready = 1'b1;
    #1;
    cmp("hold_ack", ack, 0);
    tick();
    cmp("hold_count_a", count, 2);
    tick();
    cmp("hold_count_b", count, 2);
    rdy = 1'b1; req = 1'b0; cdbv = 1'b0;
    #1;
    cmp("hold_cv", cv, 0);
    cmp("hold_alloc_tag", atag, 2);

    // Writeback to the head with commit ready: bypass retires at once.
    cdbv = 1'b1; cdbt = 5'd0;
    #1;
`ifdef ROB_CDB_BYPASS_EN
    cmp("byp_cv_same", cv, 1);
    tick();
    cmp("byp_head_next", ctag, 1);
`else
    cmp("byp_cv_same", cv, 0);
    tick();
    cmp("byp_cv_next", cv, 1);
`endif
    cdbt = 5'd1;
    tick();
    cdbv = 1'b0;
    wait_empty("byp_drain_empty");
    cready = 1'b0;

    // flush_out held while rdy is low.
    alloc_n(1);
    cdbv = 1'b1; cdbt = 5'd2; cdbm = 1'b1; tick();
    cdbv = 1'b0; cdbm = 1'b0; cready = 1'b1;
    tick();
    rdy = 1'b0; cready = 1'b0;
    cmp("fhold_a", flush, 1);
    tick();
    cmp("fhold_b", flush, 1);
    rdy = 1'b1;
    tick();
    cmp("fhold_release", flush, 0);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rob_ctrl.md
# rob_ctrl

Allocation and in-order retirement controller for the reorder buffer in the out-of-order RISC-V core. It owns the head/tail pointers, the per-entry valid/ready/mispredict status bits, and the full/empty flags. It hands ROB tags to the issue stage, absorbs CDB writebacks, sequences one commit per cycle to the register file/store path, and raises a flush on a mispredicted branch. Instruction payload storage stays in the ROB data array, which this block addresses only by tag.

## Interface
- DEPTH, 32, number of ROB entries; must be a power of two ≥ 2
- TAG_W, 5, log2(DEPTH); width of every tag port
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; when low, all state holds and no handshake completes
- alloc_req_in  in  1  issue stage requests one entry
- alloc_ack_out  out  1  entry granted this cycle
- alloc_tag_out  out  TAG_W  tag of the granted entry (current tail)
- cdb_valid_in  in  1  writeback broadcast valid
- cdb_tag_in  in  TAG_W  tag being completed
- cdb_mispredict_in  in  1  completed instruction is a mispredicted branch
- commit_valid_out  out  1  head entry may retire
- commit_tag_out  out  TAG_W  head tag
- commit_ready_in  in  1  downstream accepts the retirement
- flush_out  out  1  one-cycle registered flush pulse
- full_out  out  1  count == DEPTH
- empty_out  out  1  count == 0
- count_out  out  TAG_W+1  occupied entries

## Operation
- State: head, tail (TAG_W, natural wrap), count (TAG_W+1), and valid/ready/mispred bit vectors of DEPTH bits.
- Allocation: alloc_ack_out = rdy_in & alloc_req_in & !full_out & !flush_commit. On ack: valid[tail]=1, ready[tail]=0, mispred[tail]=0, tail+1.
- Writeback: when rdy_in & cdb_valid_in & valid[cdb_tag_in], set ready[cdb_tag_in]=1 and mispred[cdb_tag_in]=cdb_mispredict_in. Writeback to an invalid entry is ignored.
- Commit: commit_valid_out = valid[head] & ready[head]. A retirement occurs when rdy_in & commit_valid_out & commit_ready_in; it clears valid[head] and increments head.
- flush_commit = retirement & mispred[head]. At that edge, head, tail, and count go to 0 and all bit vectors clear. flush_out is 1 for the following cycle. Any simultaneous allocation is refused and any simultaneous writeback is discarded.
- count update: +1 on ack only, −1 on retire only, unchanged when both occur. The flush rule overrides this.
- Full: no ack, even if a retirement occurs in the same cycle; the full flag uses the registered count. Empty: commit_valid_out = 0.

## Timing
- Reset values: head, tail, and count = 0. All bits = 0. flush_out = 0, alloc_ack_out = 0, commit_valid_out = 0, empty_out = 1, full_out = 0, alloc_tag_out = 0, commit_tag_out = 0.
- alloc_ack_out and alloc_tag_out are combinational from registered state and inputs. The tag is valid in the ack cycle.
- The earliest writeback to a new tag is the cycle after its ack.
- The earliest commit is the cycle after the writeback edge; the bypass option changes this.
- flush_out is registered and goes high exactly 1 cycle after the flushing retirement.
- rdy_in low: every register holds, including flush_out.
- Asserting rst_in mid-operation immediately clears all state; in-flight tags are lost.

## Configuration
- ROB_CDB_BYPASS_EN defined: commit_valid_out additionally asserts when valid[head] & cdb_valid_in & cdb_tag_in == head. In that case the mispredict decision uses cdb_mispredict_in, giving same-cycle retire on writeback.
- Not defined: commit sees only registered ready bits, so there is a 1-cycle writeback-to-commit latency.

## Structure
- The shared definitions package holds the ROB_DEPTH and ROB_TAG_W constants and the tag type. Issue stage, reservation stations, and the ROB data array import them.
- One sub-module, rob_ptr_counter: a wrapping TAG_W pointer with inc and clear inputs, instantiated for head and tail.

## Test plan
- Reset then idle: empty_out = 1, count_out = 0, commit_valid_out = 0, flush_out = 0.
- 32 back-to-back requests → tags 0..31 acked, full_out = 1. 33rd request → alloc_ack_out = 0.
- Allocate 3, writeback tags 2, 1, 0 in consecutive cycles → commits tag 0, 1, 2 in order on consecutive cycles, then empty_out = 1.
- Allocate 4, mispredict writeback on tag 1, retire 0 and 1 → flush_out high one cycle later; count_out = 0 and next alloc_tag_out = 0.
- commit_ready_in low for 3 cycles with ready head → head held, commit_tag_out stable. A simultaneous alloc at count 31 raises full_out.
- rdy_in low for 2 cycles with alloc_req_in and cdb_valid_in asserted → no state change. With ROB_CDB_BYPASS_EN, writeback to head retires in the same cycle.
